// File: rtl/custom_axi_ip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : custom_axi_ip_pkg
// Description : Shared types and constants for the custom_axi_ip block.
//               Holds the IP status encoding, the register map offsets,
//               the AXI response codes, the STATUS register bit layout and
//               the register-select encoding used by the register file.
// Revision    : 1.1 - register map, response codes and status bits added
// ============================================================================
package custom_axi_ip_pkg;

    // Status reported by the IP core on hw_status_i
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } status_e;

    // Byte offsets of the software-visible registers
    localparam logic [11:0] CTRL_OFF     = 12'h000;
    localparam logic [11:0] DATA_IN_OFF  = 12'h004;
    localparam logic [11:0] DATA_OUT_OFF = 12'h008;
    localparam logic [11:0] STATUS_OFF   = 12'h00C;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    // STATUS register layout
    localparam int STATUS_HW_LSB   = 0;
    localparam int STATUS_DONE_BIT = 8;
    localparam int STATUS_ERR_BIT  = 9;

    // Decoded register select
    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_DATA_IN  = 3'd1,
        REG_DATA_OUT = 3'd2,
        REG_STATUS   = 3'd3,
        REG_NONE     = 3'd4
    } reg_sel_e;

    // Merge write data into a 32-bit word, byte lane by byte lane
    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/custom_axi_ip_regs.sv
`default_nettype none
// ============================================================================
// Module      : custom_axi_ip_regs
// Description : AXI4-Lite responder and register file for custom_axi_ip.
//               Software loads the operand (DATA_IN) and issues START via
//               CTRL; the block drives ipreg_data_o and a one-cycle
//               enable_o pulse. Results strobed in on hw_wen_i land in
//               DATA_OUT and set the sticky DONE flag in STATUS.
// Ports       : clk_i/rst_i         clock, synchronous active-high reset
//               s_aw*/s_w*/s_b*     AXI4-Lite write address/data/response
//               s_ar*/s_r*          AXI4-Lite read address/data
//               ipreg_data_o        operand to IP (DATA_IN)
//               enable_o            start pulse to IP
//               hw_data_i/hw_wen_i  result from IP and its valid strobe
//               hw_status_i         live IP status (status_e)
// Revision    : 1.0 - initial release
// ============================================================================
module custom_axi_ip_regs
    import custom_axi_ip_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
    input  logic                  s_awvalid_i,
    output logic                  s_awready_o,
    input  logic [DATA_WIDTH-1:0] s_wdata_i,
    input  logic [3:0]            s_wstrb_i,
    input  logic                  s_wvalid_i,
    output logic                  s_wready_o,
    output logic [1:0]            s_bresp_o,
    output logic                  s_bvalid_o,
    input  logic                  s_bready_i,
    input  logic [ADDR_WIDTH-1:0] s_araddr_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [1:0]            s_rresp_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    output logic [DATA_WIDTH-1:0] ipreg_data_o,
    output logic                  enable_o,
    input  logic [DATA_WIDTH-1:0] hw_data_i,
    input  logic                  hw_wen_i,
    input  logic [1:0]            hw_status_i
);

    // Write-side one-entry buffers
    logic                  r_aw_held;
    logic [ADDR_WIDTH-1:0] r_aw_addr;
    logic                  r_w_held;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;

    // Read-side registers
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;

    // Register bank
    logic [DATA_WIDTH-1:0] r_data_in;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_done;
    logic                  r_err;
    logic                  r_enable;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_ar_hs;
    logic                  w_do_write;
    logic                  w_any_strb;
    logic                  w_hw_idle;
    logic                  w_start_req;
    logic                  w_clr_done;
    logic                  w_clr_err;
    reg_sel_e              w_wsel;
    reg_sel_e              w_rsel;
    logic [1:0]            w_wr_resp;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]            w_rd_resp;

    // Word-aligned decode; byte-offset bits inside a word are ignored
    function automatic reg_sel_e decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        word = addr & ~ADDR_WIDTH'(3);
        if (word == ADDR_WIDTH'(CTRL_OFF))     return REG_CTRL;
        if (word == ADDR_WIDTH'(DATA_IN_OFF))  return REG_DATA_IN;
        if (word == ADDR_WIDTH'(DATA_OUT_OFF)) return REG_DATA_OUT;
        if (word == ADDR_WIDTH'(STATUS_OFF))   return REG_STATUS;
        return REG_NONE;
    endfunction

    // No new AW/W is taken while a response is outstanding
    assign s_awready_o  = !r_aw_held && !r_bvalid;
    assign s_wready_o   = !r_w_held && !r_bvalid;
    assign s_arready_o  = !r_rvalid;
    assign s_bvalid_o   = r_bvalid;
    assign s_bresp_o    = r_bresp;
    assign s_rvalid_o   = r_rvalid;
    assign s_rdata_o    = r_rdata;
    assign s_rresp_o    = r_rresp;
    assign ipreg_data_o = r_data_in;
    assign enable_o     = r_enable;

    assign w_aw_hs    = s_awvalid_i && s_awready_o;
    assign w_w_hs     = s_wvalid_i && s_wready_o;
    assign w_ar_hs    = s_arvalid_i && s_arready_o;
    assign w_do_write = r_aw_held && r_w_held;
    assign w_any_strb = |r_wstrb;
    assign w_wsel     = decode(r_aw_addr);
    assign w_rsel     = decode(s_araddr_i);
    assign w_hw_idle  = (status_e'(hw_status_i) == ST_IDLE);

    assign w_start_req = w_do_write && (w_wsel == REG_CTRL) && r_wstrb[0] && r_wdata[0];
    assign w_clr_done  = w_do_write && (w_wsel == REG_STATUS) && r_wstrb[1]
                         && r_wdata[STATUS_DONE_BIT];
    assign w_clr_err   = w_do_write && (w_wsel == REG_STATUS) && r_wstrb[1]
                         && r_wdata[STATUS_ERR_BIT];

    // Write response: an all-zero strobe is a harmless no-op on mapped space
    always_comb begin
        w_wr_resp = RESP_OKAY;
        case (w_wsel)
            REG_DATA_OUT: if (w_any_strb) w_wr_resp = RESP_SLVERR;
            REG_NONE:     w_wr_resp = RESP_DECERR;
            default:      w_wr_resp = RESP_OKAY;
        endcase
    end

    // Read mux samples the bank before any same-edge write lands
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (w_rsel)
            REG_DATA_IN:  w_rd_data = r_data_in;
            REG_DATA_OUT: w_rd_data = r_data_out;
            REG_STATUS: begin
                w_rd_data[STATUS_HW_LSB +: 2] = hw_status_i;
                w_rd_data[STATUS_DONE_BIT]    = r_done;
                w_rd_data[STATUS_ERR_BIT]     = r_err;
            end
            REG_NONE:     w_rd_resp = RESP_DECERR;
            default:      w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_aw_held  <= 1'b0;
            r_aw_addr  <= '0;
            r_w_held   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_data_in  <= '0;
            r_data_out <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_enable   <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= s_awaddr_i;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_wdata_i;
                r_wstrb  <= s_wstrb_i;
            end

            if (w_do_write) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_resp;
            end else if (r_bvalid && s_bready_i) begin
                r_bvalid <= 1'b0;
            end

            if (w_do_write && (w_wsel == REG_DATA_IN)) begin
                r_data_in <= apply_wstrb(r_data_in, r_wdata, r_wstrb);
            end

            // START only fires toward an idle IP; otherwise it is flagged
            r_enable <= w_start_req && w_hw_idle;
            if (w_start_req && !w_hw_idle) begin
                r_err <= 1'b1;
            end else if (w_clr_err) begin
                r_err <= 1'b0;
            end

            // A fresh result beats a simultaneous software clear
            if (hw_wen_i) begin
                r_data_out <= hw_data_i;
                r_done     <= 1'b1;
            end else if (w_clr_done) begin
                r_done <= 1'b0;
            end

            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
                r_rresp  <= w_rd_resp;
            end else if (r_rvalid && s_rready_i) begin
                r_rvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
